// File: rtl/fb_stream_reader.sv
// ----------------------------------------------------------------------------
// fb_stream_reader
//
// Walks a H_RES x V_RES RGB444 frame buffer in raster order and turns it into
// an Avalon-ST video stream (30-bit RGB, SOP on the first pixel, EOP on the
// last). Frames are streamed back-to-back while enable stays high.
//
// RAM read latency is hidden behind an RD_LAT-deep in-flight pipe. A
// show-ahead FIFO absorbs back-pressure. Reads are only issued while a FIFO
// slot is guaranteed for them, so stalling src_ready never drops or repeats
// a pixel.
//
// Ports
//   clk          pixel clock
//   reset_n      synchronous, active-low reset
//   enable       high: stream frames continuously; low: stop after this frame
//   rd_address   frame-buffer read address (raster index)
//   rd_en        high when rd_address is a real read issue
//   rd_data      RAM q {R4,G4,B4}, valid RD_LAT cycles after the issue
//   src_data     {R10,G10,B10}
//   src_valid    Avalon-ST valid (FIFO not empty)
//   src_ready    Avalon-ST ready, readyLatency 0
//   src_sop      start of packet, qualified by src_valid
//   src_eop      end of packet, qualified by src_valid
//   busy         controller is not idle
//   frame_count  completed frames (EOP beats accepted), wraps at 2^16
//
// Parameter constraints: H_RES*V_RES <= 2**ADDR_W, 1 <= RD_LAT <= 4,
// FIFO_DEPTH >= RD_LAT+2 for one beat per cycle with src_ready held high.
// ----------------------------------------------------------------------------
module fb_stream_reader #(
  parameter int H_RES      = 320,
  parameter int V_RES      = 240,
  parameter int ADDR_W     = 17,
  parameter int RD_LAT     = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  output logic [ADDR_W-1:0] rd_address,
  output logic              rd_en,
  input  logic [11:0]       rd_data,
  output logic [29:0]       src_data,
  output logic              src_valid,
  input  logic              src_ready,
  output logic              src_sop,
  output logic              src_eop,
  output logic              busy,
  output logic [15:0]       frame_count
);

  localparam int COL_W = (H_RES > 1) ? $clog2(H_RES) : 1;
  localparam int ROW_W = (V_RES > 1) ? $clog2(V_RES) : 1;
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  // Wide enough for in-flight reads plus FIFO occupancy.
  localparam int CRD_W = $clog2(RD_LAT + FIFO_DEPTH + 1);

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(H_RES - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(V_RES - 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);
  localparam logic [CRD_W-1:0] CRD_MAX  = CRD_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN
  } state_e;

  typedef struct packed {
    logic        sop;
    logic        eop;
    logic [29:0] data;
  } beat_t;

  // Each 4-bit channel c becomes {c, c, 2'b00}: 0xF -> 0x3FC, 0x0 -> 0x000.
  function automatic logic [29:0] expand_rgb(input logic [11:0] p);
    return {p[11:8], p[11:8], 2'b00,
            p[7:4],  p[7:4],  2'b00,
            p[3:0],  p[3:0],  2'b00};
  endfunction

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [COL_W-1:0]    col_q, col_d;
  logic [ROW_W-1:0]    row_q, row_d;

  logic [RD_LAT-1:0]   pipe_vld_q, pipe_vld_d;
  logic [RD_LAT-1:0]   pipe_sop_q, pipe_sop_d;
  logic [RD_LAT-1:0]   pipe_eop_q, pipe_eop_d;

  beat_t               fifo_mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;

  logic [15:0]         frame_count_q, frame_count_d;

  // --------------------------------------------------------------------------
  // Datapath helpers
  // --------------------------------------------------------------------------
  logic [CRD_W-1:0]    inflight;
  logic                credit_ok;
  logic                issue;
  logic                last_pix;
  logic                first_pix;
  logic                push;
  logic                pop;
  logic                fifo_empty;
  beat_t               head;
  beat_t               push_beat;

  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LAT; i++) begin
      inflight = inflight + CRD_W'(pipe_vld_q[i]);
    end
  end

  // A read may only be issued if a FIFO slot is already reserved for it.
  // A pop in the same cycle is not counted, so issue resumes the cycle after.
  assign credit_ok  = (inflight + CRD_W'(count_q)) < CRD_MAX;
  assign issue      = (state_q == ST_RUN) && credit_ok;
  assign last_pix   = (col_q == COL_LAST) && (row_q == ROW_LAST);
  assign first_pix  = (col_q == '0) && (row_q == '0);

  assign fifo_empty = (count_q == '0);
  assign head       = fifo_mem_q[rd_ptr_q];
  assign push       = pipe_vld_q[RD_LAT-1];
  assign pop        = !fifo_empty && src_ready;

  assign push_beat  = '{sop:  pipe_sop_q[RD_LAT-1],
                        eop:  pipe_eop_q[RD_LAT-1],
                        data: expand_rgb(rd_data)};

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets a default before any branch so no latch is inferred.
    state_d = state_q;
    addr_d  = addr_q;
    col_d   = col_q;
    row_d   = row_q;

    unique case (state_q)
      ST_IDLE:  if (enable) state_d = ST_RUN;
      // enable is only looked at when the last pixel of a frame is issued,
      // so a frame is never truncated.
      ST_RUN:   if (issue && last_pix && !enable) state_d = ST_DRAIN;
      ST_DRAIN: if ((inflight == '0) && fifo_empty) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    // Raster walk is purely incremental: the address tracks col/row, no multiply.
    if (issue) begin
      if (last_pix) begin
        addr_d = '0;
        col_d  = '0;
        row_d  = '0;
      end else if (col_q == COL_LAST) begin
        addr_d = addr_q + 1'b1;
        col_d  = '0;
        row_d  = row_q + 1'b1;
      end else begin
        addr_d = addr_q + 1'b1;
        col_d  = col_q + 1'b1;
      end
    end
  end

  // In-flight pipe mirrors the RAM latency so tags line up with rd_data.
  always_comb begin
    pipe_vld_d    = pipe_vld_q;
    pipe_sop_d    = pipe_sop_q;
    pipe_eop_d    = pipe_eop_q;
    pipe_vld_d[0] = issue;
    pipe_sop_d[0] = issue && first_pix;
    pipe_eop_d[0] = issue && last_pix;
    for (int i = 1; i < RD_LAT; i++) begin
      pipe_vld_d[i] = pipe_vld_q[i-1];
      pipe_sop_d[i] = pipe_sop_q[i-1];
      pipe_eop_d[i] = pipe_eop_q[i-1];
    end
  end

  // FIFO pointers wrap explicitly so FIFO_DEPTH need not be a power of two.
  always_comb begin
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    frame_count_d = frame_count_q;

    if (push) wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;

    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    if (pop && head.eop) frame_count_d = frame_count_q + 1'b1;
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments; reset is sampled on the clock edge.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      addr_q        <= '0;
      col_q         <= '0;
      row_q         <= '0;
      pipe_vld_q    <= '0;
      pipe_sop_q    <= '0;
      pipe_eop_q    <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      frame_count_q <= '0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      col_q         <= col_d;
      row_q         <= row_d;
      pipe_vld_q    <= pipe_vld_d;
      pipe_sop_q    <= pipe_sop_d;
      pipe_eop_q    <= pipe_eop_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      frame_count_q <= frame_count_d;
    end
  end

  // NOTE: FIFO storage is not reset; clearing the pointers and count empties it.
  always_ff @(posedge clk) begin
    if (push) fifo_mem_q[wr_ptr_q] <= push_beat;
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  // Head fields are masked while empty so stale storage never reaches the port.
  assign rd_address  = addr_q;
  assign rd_en       = issue;
  assign src_valid   = !fifo_empty;
  assign src_data    = fifo_empty ? '0 : head.data;
  assign src_sop     = !fifo_empty && head.sop;
  assign src_eop     = !fifo_empty && head.eop;
  assign busy        = (state_q != ST_IDLE);
  assign frame_count = frame_count_q;

  // --------------------------------------------------------------------------
  // Invariants of the credit scheme
  // --------------------------------------------------------------------------
  a_fifo_no_overflow: assert property (@(posedge clk) disable iff (!reset_n)
    !(push && !pop && (count_q == CNT_FULL)));

  a_fifo_no_underflow: assert property (@(posedge clk) disable iff (!reset_n)
    !(pop && fifo_empty));

  a_credit_bound: assert property (@(posedge clk) disable iff (!reset_n)
    (inflight + CRD_W'(count_q)) <= CRD_MAX);

endmodule

// File: tb/tb_fb_stream_reader.sv
// ----------------------------------------------------------------------------
// tb_fb_stream_reader
//
// Four instances share one clock:
//   c0: 320x240, RD_LAT=2, depth 4  - latency, full-frame throughput, pins
//   c1: 8x4,     RD_LAT=1, depth 3  - alignment, back-pressure, drain
//   c2: 8x4,     RD_LAT=4, depth 6  - alignment, back-pressure, drain
//   c3: 40x30,   RD_LAT=2, depth 4  - enable drop at pixel 1000, mid-frame reset
// Each instance has a RAM returning mem[a] = a[11:0] after RD_LAT cycles and
// a model that predicts every beat from the count of accepted beats.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_fb_stream_reader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [3:0]  rstn_v = '0;
  logic [3:0]  en_v   = '0;
  logic [3:0]  rdy_v  = '0;
  logic [3:0]  vld_v, sop_v, eop_v, busy_v, rden_v;
  logic [29:0] data_a [4];
  logic [15:0] fc_a   [4];

  task automatic check(input int inst, input string name,
                       input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL c%0d %s: got 0x%0h, want 0x%0h (t=%0t)", inst, name, act, exp, $time);
    end
  endtask

  // 4-bit channel c becomes c*68 (= c<<6 | c<<2) in 10 bits.
  function automatic logic [29:0] expand_px(input int p);
    int r, g, b;
    r = (p >> 8) & 15;
    g = (p >> 4) & 15;
    b = p & 15;
    return 30'((r * 68) * 1048576 + (g * 68) * 1024 + b * 68);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // --------------------------------------------------------------------------
  // Instances, RAM models and per-instance reference model
  // --------------------------------------------------------------------------
  for (genvar g = 0; g < 4; g++) begin : g_cfg
    localparam int H    = (g == 0) ? 320 : (g == 3) ? 40 : 8;
    localparam int V    = (g == 0) ? 240 : (g == 3) ? 30 : 4;
    localparam int L    = (g == 1) ? 1 : (g == 2) ? 4 : 2;
    localparam int D    = L + 2;
    localparam int NPIX = H * V;

    logic [16:0] rd_address;
    logic        rd_en;
    logic [11:0] rd_data;
    logic [29:0] src_data;
    logic        src_valid, src_sop, src_eop, busy;
    logic [15:0] frame_count;
    logic [11:0] ram_q [L];

    fb_stream_reader #(
      .H_RES(H), .V_RES(V), .ADDR_W(17), .RD_LAT(L), .FIFO_DEPTH(D)
    ) dut (
      .clk         (clk),
      .reset_n     (rstn_v[g]),
      .enable      (en_v[g]),
      .rd_address  (rd_address),
      .rd_en       (rd_en),
      .rd_data     (rd_data),
      .src_data    (src_data),
      .src_valid   (src_valid),
      .src_ready   (rdy_v[g]),
      .src_sop     (src_sop),
      .src_eop     (src_eop),
      .busy        (busy),
      .frame_count (frame_count)
    );

    // RAM with mem[a] = a[11:0] and L cycles of read latency.
    always @(posedge clk) begin
      ram_q[0] <= rd_address[11:0];
      for (int i = 1; i < L; i++) ram_q[i] <= ram_q[i-1];
    end
    assign rd_data = ram_q[L-1];

    assign vld_v[g]  = src_valid;
    assign sop_v[g]  = src_sop;
    assign eop_v[g]  = src_eop;
    assign busy_v[g] = busy;
    assign rden_v[g] = rd_en;
    assign data_a[g] = src_data;
    assign fc_a[g]   = frame_count;

    // Reset level the DUT saw at the most recent edge.
    logic rst_smp = 1'b0;
    always @(posedge clk) rst_smp <= rstn_v[g];

    int          acc = 0;       // beats accepted since reset
    int          iss = 0;       // reads issued since reset
    int          frames_m = 0;  // EOP beats accepted since reset
    int          pix;
    logic        prev_stall = 1'b0;
    logic [29:0] prev_data;
    logic        prev_sop, prev_eop;

    always @(negedge clk) begin
      if (!rst_smp) begin
        check(g, "rst_valid", 32'(src_valid), 32'd0);
        check(g, "rst_sop", 32'(src_sop), 32'd0);
        check(g, "rst_eop", 32'(src_eop), 32'd0);
        check(g, "rst_busy", 32'(busy), 32'd0);
        check(g, "rst_rd_en", 32'(rd_en), 32'd0);
        check(g, "rst_rd_address", 32'(rd_address), 32'd0);
        check(g, "rst_frame_count", 32'(frame_count), 32'd0);
        acc        = 0;
        iss        = 0;
        frames_m   = 0;
        prev_stall = 1'b0;
      end else begin
        check(g, "frame_count", 32'(frame_count), 32'(16'(frames_m)));
        check(g, "outstanding<=depth", 32'((iss - acc) <= D), 32'd1);
        if (rd_en) begin
          // Outstanding = in flight + queued, not counting this cycle's pop.
          check(g, "issue_credit", 32'((iss - acc) < D), 32'd1);
          check(g, "rd_address", 32'(rd_address), 32'(iss % NPIX));
        end
        if (prev_stall) begin
          check(g, "stall_valid", 32'(src_valid), 32'd1);
          check(g, "stall_data", 32'(src_data), 32'(prev_data));
          check(g, "stall_sop", 32'(src_sop), 32'(prev_sop));
          check(g, "stall_eop", 32'(src_eop), 32'(prev_eop));
        end
        if (src_valid) begin
          pix = acc % NPIX;
          check(g, "beat_was_issued", 32'(acc < iss), 32'd1);
          check(g, "data", 32'(src_data), 32'(expand_px(pix % 4096)));
          check(g, "sop", 32'(src_sop), 32'(pix == 0));
          check(g, "eop", 32'(src_eop), 32'(pix == NPIX - 1));
          prev_data = src_data;
          prev_sop  = src_sop;
          prev_eop  = src_eop;
          if (rdy_v[g]) begin
            acc++;
            if (pix == NPIX - 1) frames_m++;
          end
        end
        if (rd_en) iss++;
        prev_stall = src_valid && !rdy_v[g];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Directed sequences
  // --------------------------------------------------------------------------
  // Back-to-back frames, random and held back-pressure, then drain.
  task automatic small_run(input int i, input int npix);
    int k;
    int beats;
    rstn_v[i] = 1'b0; en_v[i] = 1'b0; rdy_v[i] = 1'b1;
    repeat (2) step();
    rstn_v[i] = 1'b1; en_v[i] = 1'b1;
    k = 0;
    while (!vld_v[i] && k < 20) begin step(); k++; end
    check(i, "first_valid", 32'(vld_v[i]), 32'd1);
    check(i, "first_sop", 32'(sop_v[i]), 32'd1);
    check(i, "first_data", 32'(data_a[i]), 32'd0);
    beats = 0;
    for (int c = 0; c < 2 * npix; c++) begin
      if (vld_v[i]) beats++;
      step();
    end
    check(i, "b2b_beats", 32'(beats), 32'(2 * npix));
    check(i, "b2b_frame_count", 32'(fc_a[i]), 32'd2);
    for (int c = 0; c < 300; c++) begin
      rdy_v[i] = 1'($urandom_range(0, 1));
      step();
    end
    rdy_v[i] = 1'b0;
    repeat (20) step();
    check(i, "held_stall_valid", 32'(vld_v[i]), 32'd1);
    check(i, "held_stall_no_issue", 32'(rden_v[i]), 32'd0);
    rdy_v[i] = 1'b1;
    step();
    check(i, "issue_after_pop", 32'(rden_v[i]), 32'd1);
    en_v[i] = 1'b0;
    k = 0;
    while (busy_v[i] && k < 4 * npix + 50) begin step(); k++; end
    check(i, "drain_done", 32'(busy_v[i]), 32'd0);
    check(i, "drain_empty", 32'(vld_v[i]), 32'd0);
    rstn_v[i] = 1'b0;
  endtask

  // Enable dropped at pixel 1000, then a one-cycle reset in the middle of a frame.
  task automatic enable_reset_run(input int i);
    int k;
    int beats;
    int extra;
    rstn_v[i] = 1'b0; en_v[i] = 1'b0; rdy_v[i] = 1'b1;
    repeat (2) step();
    rstn_v[i] = 1'b1; en_v[i] = 1'b1;
    beats = 0; k = 0;
    while (beats < 1000 && k < 2000) begin
      if (vld_v[i] && rdy_v[i]) beats++;
      step(); k++;
    end
    check(i, "reached_1000", 32'(beats), 32'd1000);
    en_v[i] = 1'b0;
    k = 0;
    while (!(vld_v[i] && eop_v[i]) && k < 400) begin step(); k++; end
    check(i, "eop_seen", 32'(vld_v[i] && eop_v[i]), 32'd1);
    check(i, "fc_before_eop", 32'(fc_a[i]), 32'd0);
    step();
    check(i, "fc_after_eop", 32'(fc_a[i]), 32'd1);
    k = 0;
    while (busy_v[i] && k < 20) begin step(); k++; end
    check(i, "busy_fell", 32'(busy_v[i]), 32'd0);
    extra = 0;
    for (int c = 0; c < 30; c++) begin
      if (rden_v[i] || vld_v[i]) extra++;
      step();
    end
    check(i, "quiet_after_drain", 32'(extra), 32'd0);

    en_v[i] = 1'b1;
    for (int c = 0; c < 100; c++) begin
      rdy_v[i] = 1'($urandom_range(0, 1));
      step();
    end
    rstn_v[i] = 1'b0;
    step();
    check(i, "midrst_valid", 32'(vld_v[i]), 32'd0);
    check(i, "midrst_busy", 32'(busy_v[i]), 32'd0);
    check(i, "midrst_fc", 32'(fc_a[i]), 32'd0);
    check(i, "midrst_rd_en", 32'(rden_v[i]), 32'd0);
    rstn_v[i] = 1'b1; rdy_v[i] = 1'b1;
    k = 0;
    while (!vld_v[i] && k < 20) begin step(); k++; end
    check(i, "restart_valid", 32'(vld_v[i]), 32'd1);
    check(i, "restart_sop", 32'(sop_v[i]), 32'd1);
    check(i, "restart_data", 32'(data_a[i]), 32'd0);
    repeat (50) step();
    rstn_v[i] = 1'b0;
  endtask

  initial begin
    fork
      begin : thr_default
        int gaps;
        rdy_v[0] = 1'b1; en_v[0] = 1'b0;
        repeat (3) step();
        rstn_v[0] = 1'b1;
        step();
        check(0, "idle_busy", 32'(busy_v[0]), 32'd0);
        check(0, "idle_valid", 32'(vld_v[0]), 32'd0);
        en_v[0] = 1'b1;
        // Next edge samples enable; "cycle n" is the n-th clock period after it.
        step();
        check(0, "cyc1_rd_en", 32'(rden_v[0]), 32'd1);
        check(0, "cyc1_valid", 32'(vld_v[0]), 32'd0);
        step();
        check(0, "cyc2_valid", 32'(vld_v[0]), 32'd0);
        step();
        check(0, "cyc3_valid", 32'(vld_v[0]), 32'd0);
        step();
        check(0, "cyc4_valid", 32'(vld_v[0]), 32'd1);
        check(0, "cyc4_sop", 32'(sop_v[0]), 32'd1);
        gaps = 0;
        for (int i = 0; i < 76800; i++) begin
          if (!vld_v[0]) gaps++;
          // 0x123 -> {0x044, 0x088, 0x0CC}; 0xFFF -> {0x3FC, 0x3FC, 0x3FC}
          if (i == 'h123) check(0, "beat_0x123", 32'(data_a[0]), 32'h044220CC);
          if (i == 'hFFF) check(0, "beat_0xfff", 32'(data_a[0]), 32'h3FCFF3FC);
          if (i == 1)     check(0, "beat1_sop", 32'(sop_v[0]), 32'd0);
          if (i == 76799) begin
            check(0, "beat76799_eop", 32'(eop_v[0]), 32'd1);
            check(0, "fc_before_eop", 32'(fc_a[0]), 32'd0);
          end
          step();
        end
        check(0, "frame_gaps", 32'(gaps), 32'd0);
        check(0, "next_sop_valid", 32'(vld_v[0]), 32'd1);
        check(0, "next_sop", 32'(sop_v[0]), 32'd1);
        check(0, "next_sop_data", 32'(data_a[0]), 32'd0);
        check(0, "fc_after_eop", 32'(fc_a[0]), 32'd1);
        rstn_v[0] = 1'b0;
        step();
        check(0, "rst_valid_now", 32'(vld_v[0]), 32'd0);
        check(0, "rst_fc_now", 32'(fc_a[0]), 32'd0);
        en_v[0] = 1'b0;
      end
      begin : thr_small
        small_run(1, 32);
        small_run(2, 32);
        enable_reset_run(3);
      end
    join
    repeat (2) step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #950000;
    $display("FAIL watchdog: simulation did not complete, got timeout, want finish");
    $fatal(1, "watchdog expired");
  end

endmodule
